// File: rtl/mem_responder_if.sv
// Request/response bundle between the memory controller (master) and
// the memory responder (slave).
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  busy;
  logic                  err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, busy, err
  );

endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word-addressed RAM responder: one request at a time,
// registered ready/busy/err outputs, read data held between reads.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t                state;
  state_t                next_state;
  logic [7:0]            counter;
  logic                  op_write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  start;
  logic                  conflict;
  logic                  commit;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    start      = (state == IDLE) && (bus.mem_read ^ bus.mem_write);
    conflict   = (state == IDLE) && bus.mem_read && bus.mem_write;
    commit     = (state == BUSY) && (counter == 8'd0);
    next_state = state;
    case (state)
      IDLE:    if (start)  next_state = BUSY;
      BUSY:    if (commit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next-state decisions so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter    <= 8'd0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bus.rdata  <= '0;
      bus.ready  <= 1'b0;
      bus.busy   <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      if (start) begin
        op_write_q <= bus.mem_write;
        addr_q     <= bus.addr;
        wdata_q    <= bus.wdata;
        counter    <= CNT_INIT;
      end else if ((state == BUSY) && (counter != 8'd0)) begin
        counter <= counter - 8'd1;
      end
      if (commit && !op_write_q) begin
        bus.rdata <= mem[addr_q];
      end
      bus.ready <= commit;
      bus.busy  <= (next_state != IDLE);
      bus.err   <= conflict;
    end
  end

  // The array has no reset; an aborted write never reaches commit because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (commit && op_write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: a LATENCY=3 instance for
// the main cases and a LATENCY=1 instance for the boundary cases.
module tb_mem_responder;

  logic clk;
  logic rst_n;
  bit   cur;
  int   n_compared;
  int   n_mismatched;

  logic        obs_ready;
  logic        obs_busy;
  logic        obs_err;
  logic [31:0] obs_rdata;

  mem_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus3 ();
  mem_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus1 ();

  mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs_ready = cur ? bus1.ready : bus3.ready;
  assign obs_busy  = cur ? bus1.busy  : bus3.busy;
  assign obs_err   = cur ? bus1.err   : bus3.err;
  assign obs_rdata = cur ? bus1.rdata : bus3.rdata;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [7:0] a, input logic [31:0] d);
    if (cur) begin
      bus1.mem_read = rd; bus1.mem_write = wr; bus1.addr = a; bus1.wdata = d;
    end else begin
      bus3.mem_read = rd; bus3.mem_write = wr; bus3.addr = a; bus3.wdata = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; for reads d is the expected read data.
  task automatic runTxn(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input int lat, input string tag);
    applyStimulus(!wr, wr, a, wr ? d : 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput({tag, "_busy"}, {31'b0, obs_busy}, 32'd1);
    for (int k = 1; k <= lat; k++) begin
      tick();
      checkOutput({tag, "_ready"}, {31'b0, obs_ready}, (k == lat) ? 32'd1 : 32'd0);
      if (k == lat && !wr) checkOutput({tag, "_rdata"}, obs_rdata, d);
    end
    tick();
    checkOutput({tag, "_ready_end"}, {31'b0, obs_ready}, 32'd0);
    checkOutput({tag, "_busy_end"}, {31'b0, obs_busy}, 32'd0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    // Reset with random request inputs on both instances
    rst_n = 1'b0;
    cur = 1'b1;
    applyStimulus(1'($urandom), 1'($urandom), 8'($urandom), $urandom);
    cur = 1'b0;
    applyStimulus(1'($urandom), 1'($urandom), 8'($urandom), $urandom);
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      cur = (s == 1);
      checkOutput("rst_ready", {31'b0, obs_ready}, 32'd0);
      checkOutput("rst_busy",  {31'b0, obs_busy},  32'd0);
      checkOutput("rst_err",   {31'b0, obs_err},   32'd0);
      checkOutput("rst_rdata", obs_rdata, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    end
    cur = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("idle_ready", {31'b0, obs_ready}, 32'd0);
      checkOutput("idle_busy",  {31'b0, obs_busy},  32'd0);
      checkOutput("idle_err",   {31'b0, obs_err},   32'd0);
      checkOutput("idle_rdata", obs_rdata, 32'h0);
    end

    // Write then read, then a write elsewhere must leave rdata held
    runTxn(1'b1, 8'h10, 32'hDEADBEEF, 3, "wr10");
    runTxn(1'b0, 8'h10, 32'hDEADBEEF, 3, "rd10");
    runTxn(1'b1, 8'h30, 32'h55667788, 3, "wr30");
    checkOutput("rdata_hold", obs_rdata, 32'hDEADBEEF);

    // Conflicting request in IDLE
    applyStimulus(1'b1, 1'b1, 8'h10, 32'h00000000);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("conf_err",  {31'b0, obs_err},  32'd1);
    checkOutput("conf_busy", {31'b0, obs_busy}, 32'd0);
    tick();
    checkOutput("conf_err_end", {31'b0, obs_err},  32'd0);
    checkOutput("conf_busy2",   {31'b0, obs_busy}, 32'd0);
    runTxn(1'b0, 8'h10, 32'hDEADBEEF, 3, "conf_rd");

    // Reset during BUSY aborts the pending write
    runTxn(1'b1, 8'h05, 32'h00001111, 3, "wr05_old");
    applyStimulus(1'b0, 1'b1, 8'h05, 32'h00001234);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("abort_busy", {31'b0, obs_busy}, 32'd1);
    tick();
    #2 rst_n = 1'b0;
    #1 checkOutput("abort_busy_async", {31'b0, obs_busy}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("abort_ready", {31'b0, obs_ready}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    runTxn(1'b0, 8'h05, 32'h00001111, 3, "abort_rd");

    // Request inputs changed during BUSY are ignored
    runTxn(1'b1, 8'h21, 32'h11112222, 3, "wr21");
    applyStimulus(1'b0, 1'b1, 8'h20, 32'hCAFEF00D);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h21, 32'h0BADF00D);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h21, 32'h0BADF00D);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h21, 32'h0BADF00D);
    tick();
    checkOutput("ign_ready", {31'b0, obs_ready}, 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    checkOutput("ign_busy_end", {31'b0, obs_busy}, 32'd0);
    runTxn(1'b0, 8'h20, 32'hCAFEF00D, 3, "ign_rd20");
    runTxn(1'b0, 8'h21, 32'h11112222, 3, "ign_rd21");

    // LATENCY=1 boundary at the top address
    cur = 1'b1;
    runTxn(1'b1, 8'hFF, 32'hA5A5A5A5, 1, "l1_wrFF");
    runTxn(1'b0, 8'hFF, 32'hA5A5A5A5, 1, "l1_rdFF");

    // Held read request on LATENCY=1 completes every third cycle
    applyStimulus(1'b1, 1'b0, 8'hFF, 32'h0);
    for (int k = 0; k < 9; k++) begin
      tick();
      checkOutput("l1_hold_ready", {31'b0, obs_ready}, (k % 3 == 1) ? 32'd1 : 32'd0);
      if (k % 3 == 1) checkOutput("l1_hold_rdata", obs_rdata, 32'hA5A5A5A5);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
